// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index, write-port record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [15:0] cnt16_t;

  // Register 0 is hard-wired to zero; writes to it are swallowed.
  localparam regbits_t REG_ZERO = 5'd0;

  // Saturation ceiling for 16-bit event counters.
  localparam cnt16_t CNT_MAX = 16'hFFFF;

  // One register-file write as it sits in the output stage.
  typedef struct packed {
    logic     wen;
    regbits_t sel;
    word_t    dat;
  } wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: on a tie the requester not granted last wins.
// Latency: purely combinational, zero cycles.
// Backpressure: a losing requester simply sees no grant and must hold its request.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,  // index of the requester granted most recently
  output logic gnt0_o,
  output logic gnt1_o
);

  // Requester 0 wins alone, or on a tie when requester 1 had the last grant.
  always_comb begin
    gnt0_o = req0_i & (~req1_i | last_grant_i);
    gnt1_o = req1_i & (~req0_i | ~last_grant_i);
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges EX and MEM writebacks onto the single register-file write port.
// Latency: a request granted at edge N is driven on WEN/wsel/wdat in cycle N+1.
// Backpressure: combinational ready per requester; only the tie loser waits, the output stage never stalls.
module rf_write_arbiter
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  // requester 0: EX/ALU writeback
  input  logic     wb0_valid,
  input  regbits_t wb0_sel,
  input  word_t    wb0_dat,
  output logic     wb0_ready,
  // requester 1: MEM/load writeback
  input  logic     wb1_valid,
  input  regbits_t wb1_sel,
  input  word_t    wb1_dat,
  output logic     wb1_ready,
  // decode-stage hazard query
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output logic     pend1,
  output logic     pend2,
  output word_t    fwd_dat,
  // register-file write port
  output logic     WEN,
  output regbits_t wsel,
  output word_t    wdat,
  // tie statistics
  output cnt16_t   conflicts
);

  wr_t    wr_q, wr_d;
  logic   last_grant_q, last_grant_d;
  cnt16_t conflicts_q, conflicts_d;

  logic arb_gnt0, arb_gnt1;
  logic take0, take1;

  rr_arb2 u_rr_arb2 (
    .req0_i       (wb0_valid),
    .req1_i       (wb1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (arb_gnt0),
    .gnt1_o       (arb_gnt1)
  );

  // Readies are masked while reset is held so nothing is accepted in the reset cycle.
  always_comb begin
    wb0_ready = nRST & arb_gnt0;
    wb1_ready = nRST & arb_gnt1;
    take0     = wb0_valid & wb0_ready;
    take1     = wb1_valid & wb1_ready;
  end

  // Next-state: load the granted write (register 0 accepted but not enabled),
  // otherwise drop WEN and keep sel/dat; pointer moves only on a grant.
  always_comb begin
    wr_d         = wr_q;
    wr_d.wen     = 1'b0;
    last_grant_d = last_grant_q;
    if (take0) begin
      wr_d         = '{wen: (wb0_sel != REG_ZERO), sel: wb0_sel, dat: wb0_dat};
      last_grant_d = 1'b0;
    end else if (take1) begin
      wr_d         = '{wen: (wb1_sel != REG_ZERO), sel: wb1_sel, dat: wb1_dat};
      last_grant_d = 1'b1;
    end
  end

  // Count every cycle with both requesters valid, sticking at the ceiling.
  always_comb begin
    conflicts_d = conflicts_q;
    if (wb0_valid && wb1_valid && (conflicts_q != CNT_MAX)) begin
      conflicts_d = conflicts_q + 16'd1;
    end
  end

  // State registers; reset discards the in-flight write and favours requester 0 on the first tie.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_q         <= '0;
      last_grant_q <= 1'b1;
      conflicts_q  <= '0;
    end else begin
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
      conflicts_q  <= conflicts_d;
    end
  end

  // Write port and hazard outputs all derive from registered state.
  always_comb begin
    WEN       = wr_q.wen;
    wsel      = wr_q.sel;
    wdat      = wr_q.dat;
    fwd_dat   = wr_q.dat;
    conflicts = conflicts_q;
    pend1     = wr_q.wen && (wr_q.sel == rsel1) && (rsel1 != REG_ZERO);
    pend2     = wr_q.wen && (wr_q.sel == rsel2) && (rsel2 != REG_ZERO);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for the register-file write arbiter.
// Latency: checks registered outputs 1 ns after each rising edge.
// Backpressure: drives valid/sel/dat directly and reads ready combinationally.
module tb_rf_write_arbiter;

  logic        CLK;
  logic        nRST;
  logic        wb0_valid;
  logic [4:0]  wb0_sel;
  logic [31:0] wb0_dat;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_sel;
  logic [31:0] wb1_dat;
  logic        wb1_ready;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic        pend1;
  logic        pend2;
  logic [31:0] fwd_dat;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [15:0] conflicts;

  int errors = 0;
  int checks = 0;

  rf_write_arbiter dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .wb0_valid (wb0_valid),
    .wb0_sel   (wb0_sel),
    .wb0_dat   (wb0_dat),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_sel   (wb1_sel),
    .wb1_dat   (wb1_dat),
    .wb1_ready (wb1_ready),
    .rsel1     (rsel1),
    .rsel2     (rsel2),
    .pend1     (pend1),
    .pend2     (pend2),
    .fwd_dat   (fwd_dat),
    .WEN       (WEN),
    .wsel      (wsel),
    .wdat      (wdat),
    .conflicts (conflicts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin : stim
    int g0;
    int g1;
    int n0;
    int n1;
    logic [31:0] exp_dat;

    nRST      = 1'b0;
    wb0_valid = 1'b0; wb0_sel = 5'd0; wb0_dat = 32'd0;
    wb1_valid = 1'b0; wb1_sel = 5'd0; wb1_dat = 32'd0;
    rsel1     = 5'd0; rsel2   = 5'd0;
    tick();
    tick();

    // Reset state
    check("rst_wen",       32'(WEN),       32'd0);
    check("rst_wsel",      32'(wsel),      32'd0);
    check("rst_wdat",      wdat,           32'd0);
    check("rst_conflicts", 32'(conflicts), 32'd0);

    // Requests during reset are refused and lost
    wb0_valid = 1'b1; wb0_sel = 5'd1; wb0_dat = 32'h11;
    wb1_valid = 1'b1; wb1_sel = 5'd2; wb1_dat = 32'h22;
    #1;
    check("rst_rdy0", 32'(wb0_ready), 32'd0);
    check("rst_rdy1", 32'(wb1_ready), 32'd0);
    tick();
    check("rst_lost_wen",   32'(WEN),       32'd0);
    check("rst_lost_confl", 32'(conflicts), 32'd0);

    nRST = 1'b1;
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
    check("idle_wen", 32'(WEN), 32'd0);

    // Tie after reset: wb0 first, then wb1
    wb0_valid = 1'b1; wb0_sel = 5'd3; wb0_dat = 32'hA0;
    wb1_valid = 1'b1; wb1_sel = 5'd4; wb1_dat = 32'hB0;
    #1;
    check("tie_rdy0", 32'(wb0_ready), 32'd1);
    check("tie_rdy1", 32'(wb1_ready), 32'd0);
    tick();
    wb0_valid = 1'b0;
    check("tie_wen_a",  32'(WEN),  32'd1);
    check("tie_wsel_a", 32'(wsel), 32'd3);
    check("tie_wdat_a", wdat,      32'hA0);
    #1;
    check("tie_rdy1_b", 32'(wb1_ready), 32'd1);
    tick();
    wb1_valid = 1'b0;
    check("tie_wen_b",  32'(WEN),       32'd1);
    check("tie_wsel_b", 32'(wsel),      32'd4);
    check("tie_wdat_b", wdat,           32'hB0);
    check("tie_confl",  32'(conflicts), 32'd1);

    // Single requester, then idle holds sel/dat with WEN low
    wb0_valid = 1'b1; wb0_sel = 5'd5; wb0_dat = 32'hDEADBEEF;
    #1;
    check("single_rdy0", 32'(wb0_ready), 32'd1);
    tick();
    wb0_valid = 1'b0;
    check("single_wen",  32'(WEN),  32'd1);
    check("single_wsel", 32'(wsel), 32'd5);
    check("single_wdat", wdat,      32'hDEADBEEF);
    tick();
    check("hold_wen",  32'(WEN),  32'd0);
    check("hold_wsel", 32'(wsel), 32'd5);
    check("hold_wdat", wdat,      32'hDEADBEEF);

    // Hazard and forwarding
    wb0_valid = 1'b1; wb0_sel = 5'd9; wb0_dat = 32'h1234;
    rsel1 = 5'd9; rsel2 = 5'd2;
    tick();
    wb0_valid = 1'b0;
    check("haz_pend1", 32'(pend1), 32'd1);
    check("haz_pend2", 32'(pend2), 32'd0);
    check("haz_fwd",   fwd_dat,    32'h1234);
    rsel2 = 5'd9;
    #1;
    check("haz_pend2_same", 32'(pend2), 32'd1);
    tick();
    check("haz_drained", 32'(pend1), 32'd0);

    // Register zero: accepted, no write, no pend
    wb1_valid = 1'b1; wb1_sel = 5'd0; wb1_dat = 32'd7;
    rsel1 = 5'd0; rsel2 = 5'd2;
    #1;
    check("r0_rdy1", 32'(wb1_ready), 32'd1);
    tick();
    wb1_valid = 1'b0;
    check("r0_wen",   32'(WEN),   32'd0);
    check("r0_pend1", 32'(pend1), 32'd0);

    // Same destination from both: wb0 wins (wb1 was last), wb1's data lands last
    wb0_valid = 1'b1; wb0_sel = 5'd6; wb0_dat = 32'h60;
    wb1_valid = 1'b1; wb1_sel = 5'd6; wb1_dat = 32'h61;
    #1;
    check("same_rdy0", 32'(wb0_ready), 32'd1);
    tick();
    wb0_valid = 1'b0;
    check("same_wdat_a", wdat, 32'h60);
    tick();
    wb1_valid = 1'b0;
    check("same_wsel_b", 32'(wsel), 32'd6);
    check("same_wdat_b", wdat,      32'h61);
    check("same_confl",  32'(conflicts), 32'd2);

    // Mid-operation reset discards the in-flight write
    wb0_valid = 1'b1; wb0_sel = 5'd12; wb0_dat = 32'hC0;
    tick();
    check("mid_wen_pre", 32'(WEN), 32'd1);
    nRST = 1'b0;
    wb1_valid = 1'b1; wb1_sel = 5'd11; wb1_dat = 32'h200;
    wb0_sel = 5'd10; wb0_dat = 32'h100;
    #1;
    check("mid_rdy0", 32'(wb0_ready), 32'd0);
    check("mid_rdy1", 32'(wb1_ready), 32'd0);
    tick();
    check("mid_wen",   32'(WEN),       32'd0);
    check("mid_confl", 32'(conflicts), 32'd0);
    nRST = 1'b1;

    // Sustained contention for 10 cycles: grants 0,1,0,1,...
    g0 = 0; g1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      wb0_dat = 32'h100 + 32'(n0);
      wb1_dat = 32'h200 + 32'(n1);
      #1;
      check($sformatf("rr_rdy0_%0d", i), 32'(wb0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_rdy1_%0d", i), 32'(wb1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (wb0_ready) g0++;
      if (wb1_ready) g1++;
      exp_dat = (i % 2 == 0) ? (32'h100 + 32'(n0)) : (32'h200 + 32'(n1));
      if (i % 2 == 0) n0++; else n1++;
      tick();
      check($sformatf("rr_wdat_%0d", i), wdat, exp_dat);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    check("rr_g0",    32'(g0),        32'd5);
    check("rr_g1",    32'(g1),        32'd5);
    check("rr_confl", 32'(conflicts), 32'd10);
    tick();
    check("rr_idle_wen", 32'(WEN), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
